// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared instruction format, function codes and fetch/decode state types
package pipe_pkg;

   localparam int INSTR_W  = 24;
   localparam int FUNC_LSB = 20;
   localparam int RD_LSB   = 16;
   localparam int RS1_LSB  = 12;
   localparam int RS2_LSB  = 8;
   localparam int ADDR_LSB = 0;

   localparam logic [3:0] FUNC_ADD  = 4'd0;
   localparam logic [3:0] FUNC_SUB  = 4'd1;
   localparam logic [3:0] FUNC_MUL  = 4'd2;
   localparam logic [3:0] FUNC_DIV  = 4'd3;
   localparam logic [3:0] FUNC_AND  = 4'd4;
   localparam logic [3:0] FUNC_OR   = 4'd5;
   localparam logic [3:0] FUNC_XOR  = 4'd6;
   localparam logic [3:0] FUNC_NOT  = 4'd7;
   localparam logic [3:0] FUNC_SLT  = 4'd8;
   localparam logic [3:0] FUNC_LD   = 4'd9;
   localparam logic [3:0] FUNC_ST   = 4'd10;
   localparam logic [3:0] FUNC_SHL  = 4'd11;
   localparam logic [3:0] FUNC_HALT = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fd_state_t;

   // Field order matches the packed instruction word, so a raw word casts directly.
   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [7:0] addr;
   } instr_t;

   // Only ALU functions 0..11 produce a register result; 12..14 pass through as non-writing.
   function automatic logic func_writes(input logic [3:0] func);
      return (func <= FUNC_SHL);
   endfunction

endpackage

// File: rtl/fd_hazard_unit.sv
// rtl/fd_hazard_unit.sv - issue history shift register and RAW comparators for the interlock
module fd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int HAZARD_DIST = 2
) (
   input  logic       clk1,
   input  logic       rst_n,
   input  logic       xfer_i,
   input  logic       out_valid_i,
   input  logic [3:0] out_rd_i,
   input  logic       out_writes_i,
   input  logic [3:0] cand_rs1_i,
   input  logic [3:0] cand_rs2_i,
   output logic       hazard_o
);

   // With HAZARD_DIST==1 only the output register matters; one dummy entry keeps the array legal.
   localparam int  HIST_N   = (HAZARD_DIST > 1) ? HAZARD_DIST - 1 : 1;
   localparam bit  HIST_USE = (HAZARD_DIST > 1);

   typedef struct packed {
      logic [3:0] rd;
      logic       writes;
   } hist_t;

   hist_t hist_q [HIST_N];
   hist_t hist_d [HIST_N];

   // Shift every edge: a transfer inserts its destination, otherwise a null slot ages the history.
   always_comb begin
      for (int i = 0; i < HIST_N; i++) hist_d[i] = '0;
      hist_d[0].rd     = xfer_i ? out_rd_i : 4'd0;
      hist_d[0].writes = xfer_i && out_writes_i;
      for (int i = 1; i < HIST_N; i++) hist_d[i] = hist_q[i-1];
   end

   // History register, cleared only by reset.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
      end else begin
         for (int i = 0; i < HIST_N; i++) hist_q[i] <= hist_d[i];
      end
   end

   // Candidate blocks if either source matches a pending writer in the output register or history.
   always_comb begin
      hazard_o = out_valid_i && out_writes_i &&
                 ((cand_rs1_i == out_rd_i) || (cand_rs2_i == out_rd_i));
      for (int i = 0; i < HIST_N; i++) begin
         if (HIST_USE && hist_q[i].writes &&
             ((cand_rs1_i == hist_q[i].rd) || (cand_rs2_i == hist_q[i].rd))) begin
            hazard_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_fetch_decode.sv
// rtl/pipe_fetch_decode.sv - program memory, PC, fetch/decode FSM and issue register; interlock enabled by FD_HAZARD_INTERLOCK_EN
module pipe_fetch_decode
   import pipe_pkg::*;
#(
   parameter int IMEM_DEPTH  = 64,
   parameter int PC_W        = 6,
   parameter int HAZARD_DIST = 2
) (
   input  logic               clk1,
   input  logic               rst_n,
   input  logic               start,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [3:0]         rs1,
   output logic [3:0]         rs2,
   output logic [3:0]         rd,
   output logic [3:0]         func,
   output logic [7:0]         addr,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic               busy,
   output logic               halted,
   output logic [PC_W-1:0]    pc,
   output logic [15:0]        bubble_cnt
);

   logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];

   fd_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   instr_t          out_q, out_d;
   logic            valid_q, valid_d;
   logic [15:0]     bub_q, bub_d;

   instr_t          cand;
   logic            xfer;
   logic            slot_free;
   logic            hazard;

   assign cand      = imem_q[pc_q];
   assign xfer      = valid_q && issue_ready;
   assign slot_free = !valid_q || xfer;

`ifdef FD_HAZARD_INTERLOCK_EN
   fd_hazard_unit #(
      .HAZARD_DIST (HAZARD_DIST)
   ) u_hazard (
      .clk1         (clk1),
      .rst_n        (rst_n),
      .xfer_i       (xfer),
      .out_valid_i  (valid_q),
      .out_rd_i     (out_q.rd),
      .out_writes_i (func_writes(out_q.func)),
      .cand_rs1_i   (cand.rs1),
      .cand_rs2_i   (cand.rs2),
      .hazard_o     (hazard)
   );
`else
   assign hazard = 1'b0;
`endif

   // Program memory: writable only outside RUN, deliberately not reset.
   always_ff @(posedge clk1) begin
      if (prog_we && (state_q != RUN)) imem_q[prog_addr] <= prog_data;
   end

   // Next state, PC, issue register and bubble counter.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      valid_d = valid_q;
      bub_d   = bub_q;
      if (xfer) valid_d = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d = RUN;
               pc_d    = '0;
               bub_d   = '0;
            end
         end
         RUN: begin
            if (slot_free) begin
               if (cand.func == FUNC_HALT) begin
                  state_d = HALT;
               end else if (!hazard) begin
                  out_d   = cand;
                  valid_d = 1'b1;
                  pc_d    = pc_q + PC_W'(1);
               end else if (bub_q != 16'hFFFF) begin
                  bub_d = bub_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         bub_q   <= bub_d;
      end
   end

   assign rs1         = out_q.rs1;
   assign rs2         = out_q.rs2;
   assign rd          = out_q.rd;
   assign func        = out_q.func;
   assign addr        = out_q.addr;
   assign issue_valid = valid_q;
   assign busy        = (state_q == RUN);
   assign halted      = (state_q == HALT);
   assign pc          = pc_q;
   assign bubble_cnt  = bub_q;

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// tb/tb_pipe_fetch_decode.sv - directed self-checking bench for pipe_fetch_decode
module tb_pipe_fetch_decode;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        start;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [23:0] prog_data;
   logic [3:0]  rs1, rs2, rd, func;
   logic [7:0]  addr;
   logic        issue_valid;
   logic        issue_ready;
   logic        busy, halted;
   logic [5:0]  pc;
   logic [15:0] bubble_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          xc[$];
   logic [23:0] xw[$];

   logic [23:0] w_old3, w_new3, w_halt;
   logic [3:0]  h_rs1, h_rs2, h_rd, h_func;
   logic [7:0]  h_addr;
   int          exp_gap, exp_bub;

   pipe_fetch_decode dut (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .start       (start),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .func        (func),
      .addr        (addr),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .busy        (busy),
      .halted      (halted),
      .pc          (pc),
      .bubble_cnt  (bubble_cnt)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) cyc <= cyc + 1;

   // Log each transfer half a cycle before the edge that completes it.
   always @(negedge clk1) begin
      if (issue_valid && issue_ready) begin
         xc.push_back(cyc);
         xw.push_back({func, rd, rs1, rs2, addr});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [23:0] enc(input int f, input int d, input int s1, input int s2, input int a);
      return {4'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
   endfunction

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic load_word(input int a, input logic [23:0] w);
      prog_we   = 1'b1;
      prog_addr = 6'(a);
      prog_data = w;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      xc.delete();
      xw.delete();
   endtask

   task automatic run_to_halt(input string tag, input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
      if (!halted) check({tag, "_halt_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_xfers(input string tag, input int cnt, input int budget);
      int n;
      n = 0;
      while (xw.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      if (xw.size() < cnt) check({tag, "_xfer_timeout"}, 32'(xw.size()), 32'(cnt));
   endtask

   function automatic logic [23:0] logw(input int i);
      return (i < xw.size()) ? xw[i] : 24'hxxxxxx;
   endfunction

   function automatic int logc(input int i);
      return (i < xc.size()) ? xc[i] : -1000;
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      issue_ready = 1'b1;
`ifdef FD_HAZARD_INTERLOCK_EN
      exp_gap = 3; exp_bub = 2;
`else
      exp_gap = 1; exp_bub = 0;
`endif

      // Reset state
      #3;
      check("rst_valid",  32'(issue_valid), 32'd0);
      check("rst_pc",     32'(pc),          32'd0);
      check("rst_busy",   32'(busy),        32'd0);
      check("rst_halted", 32'(halted),      32'd0);
      check("rst_bubble", 32'(bubble_cnt),  32'd0);
      check("rst_rd",     32'(rd),          32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Independent pair then HALT: back-to-back transfers
      load_word(0, enc(0, 10, 6, 4, 125));
      load_word(1, enc(2, 10, 7, 8, 126));
      load_word(2, enc(15, 0, 0, 0, 0));
      clear_log();
      pulse_start();
      run_to_halt("t1", 30);
      check("t1_count",  32'(xw.size()),         32'd2);
      check("t1_w0",     32'(logw(0)),           32'(enc(0, 10, 6, 4, 125)));
      check("t1_w1",     32'(logw(1)),           32'(enc(2, 10, 7, 8, 126)));
      check("t1_gap",    32'(logc(1) - logc(0)), 32'd1);
      check("t1_halted", 32'(halted),            32'd1);
      check("t1_pc",     32'(pc),                32'd2);
      check("t1_bubble", 32'(bubble_cnt),        32'd0);
      check("t1_valid",  32'(issue_valid),       32'd0);

      // RAW dependency on r10
      load_word(1, enc(0, 11, 10, 1, 0));
      clear_log();
      pulse_start();
      run_to_halt("t2", 30);
      check("t2_count",  32'(xw.size()),         32'd2);
      check("t2_w1",     32'(logw(1)),           32'(enc(0, 11, 10, 1, 0)));
      check("t2_gap",    32'(logc(1) - logc(0)), 32'(exp_gap));
      check("t2_bubble", 32'(bubble_cnt),        32'(exp_bub));
      check("t2_pc",     32'(pc),                32'd2);

      // Backpressure: fields and pc hold while ready is low
      load_word(0, enc(0, 1, 2, 3, 7));
      load_word(1, enc(0, 4, 5, 6, 8));
      issue_ready = 1'b0;
      clear_log();
      pulse_start();
      check("t3_bubble_cleared", 32'(bubble_cnt), 32'd0);
      for (int n = 0; n < 10 && !issue_valid; n++) tick();
      check("t3_valid", 32'(issue_valid), 32'd1);
      for (int n = 0; n < 4; n++) begin
         h_rs1 = rs1; h_rs2 = rs2; h_rd = rd; h_func = func; h_addr = addr;
         check("t3_hold_rs1",  32'(h_rs1),  32'd2);
         check("t3_hold_rs2",  32'(h_rs2),  32'd3);
         check("t3_hold_rd",   32'(h_rd),   32'd1);
         check("t3_hold_func", 32'(h_func), 32'd0);
         check("t3_hold_addr", 32'(h_addr), 32'd7);
         check("t3_hold_pc",   32'(pc),     32'd1);
         tick();
      end
      check("t3_no_xfer", 32'(xw.size()), 32'd0);
      issue_ready = 1'b1;
      run_to_halt("t3", 30);
      check("t3_count",  32'(xw.size()), 32'd2);
      check("t3_w0",     32'(logw(0)),   32'(enc(0, 1, 2, 3, 7)));
      check("t3_gap",    32'(logc(1) - logc(0)), 32'd1);
      check("t3_pc",     32'(pc),        32'd2);
      check("t3_bubble", 32'(bubble_cnt), 32'd0);

      // PC wrap with 70 independent issues
      for (int i = 0; i < 64; i++) load_word(i, enc(0, 15, 1, 2, i));
      clear_log();
      pulse_start();
      wait_xfers("t4", 70, 200);
      check("t4_w63",  32'(logw(63)), 32'(enc(0, 15, 1, 2, 63)));
      check("t4_w64",  32'(logw(64)), 32'(enc(0, 15, 1, 2, 0)));
      check("t4_w69",  32'(logw(69)), 32'(enc(0, 15, 1, 2, 5)));
      check("t4_span", 32'(logc(69) - logc(0)), 32'd69);
      check("t4_busy", 32'(busy), 32'd1);

      // Asynchronous reset mid-RUN
      check("t5_pre_valid", 32'(issue_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_valid",  32'(issue_valid), 32'd0);
      check("t5_rs1",    32'(rs1),         32'd0);
      check("t5_pc",     32'(pc),          32'd0);
      check("t5_busy",   32'(busy),        32'd0);
      check("t5_halted", 32'(halted),      32'd0);
      tick();
      rst_n = 1'b1;
      clear_log();
      pulse_start();

      // Write while RUN must be ignored
      w_old3 = enc(0, 15, 1, 2, 3);
      w_new3 = enc(1, 9, 8, 7, 8'hAA);
      w_halt = enc(15, 0, 0, 0, 0);
      prog_we = 1'b1; prog_addr = 6'd3; prog_data = w_new3;
      tick();
      tick();
      prog_we = 1'b0;
      wait_xfers("t5", 6, 40);
      check("t5_w0",    32'(logw(0)), 32'(enc(0, 15, 1, 2, 0)));
      check("t6_run_w3", 32'(logw(3)), 32'(w_old3));

      // Back to IDLE, insert HALT at 5, then rewrite address 3 while halted
      #2;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      load_word(5, w_halt);
      clear_log();
      pulse_start();
      run_to_halt("t6a", 40);
      check("t6a_count", 32'(xw.size()), 32'd5);
      check("t6a_w3",    32'(logw(3)),   32'(w_old3));
      check("t6a_pc",    32'(pc),        32'd5);
      load_word(3, w_new3);
      clear_log();
      pulse_start();
      run_to_halt("t6b", 40);
      check("t6b_count", 32'(xw.size()), 32'd5);
      check("t6b_w3",    32'(logw(3)),   32'(w_new3));
      check("t6b_w4",    32'(logw(4)),   32'(enc(0, 15, 1, 2, 4)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pipe_fetch_decode.md
Name: pipe_fetch_decode

Overview:
Front-end stage for the 4-stage register/ALU/memory pipeline. It holds a small program memory and a PC, then fetches and decodes 24-bit instruction words. It issues rs1/rs2/rd/func/addr to the register-read stage over a valid/ready handshake. A RAW-hazard interlock inserts bubbles, because the downstream pipeline has no forwarding.

Parameters:
IMEM_DEPTH, 64, instruction words in program memory (power of 2)
PC_W, 6, PC width = log2(IMEM_DEPTH)
HAZARD_DIST, 2, issue slots after a producer during which a dependent instruction is blocked

Ports:
clk1  in  1  sole clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins execution at PC 0 from IDLE or HALT
prog_we  in  1  program-memory write enable
prog_addr  in  PC_W  program-memory write address
prog_data  in  24  instruction {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
rs1  out  4  issued source register A
rs2  out  4  issued source register B
rd  out  4  issued destination register
func  out  4  issued ALU function (0-11)
addr  out  8  issued memory store address
issue_valid  out  1  output fields hold an instruction
issue_ready  in  1  downstream accepts; a transfer occurs on an edge when valid && ready
busy  out  1  state == RUN
halted  out  1  state == HALT
pc  out  PC_W  address of the next instruction to fetch
bubble_cnt  out  16  RUN cycles blocked by hazard; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0; all issue fields, issue_valid, bubble_cnt=0; hazard history cleared. Program memory is not reset.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start. This also clears pc and bubble_cnt.
  - HALT -> RUN on start. This also clears pc and bubble_cnt.
  - start is ignored while in RUN.
- prog_we is honoured only in IDLE or HALT; it is ignored in RUN.
- Output register is 1-deep and registered. It may load when it is empty, or when a transfer occurs on the same edge.
- Load condition (RUN only): candidate = imem[pc]; the candidate is not a hazard; candidate func != 15.
- On load: fields take the decoded candidate; issue_valid=1; pc increments. pc wraps from IMEM_DEPTH-1 to 0.
- If a transfer occurs with no load: issue_valid -> 0.
- Latency: start sampled at edge T -> RUN at T; first instruction valid after edge T+1.
- HALT: candidate func==15 with the output register empty or transferring -> state HALT. The HALT word itself is never issued, and pc holds at the HALT word.
- func 12-14: issued unchanged; treated as non-writing for hazard tracking.
- Backpressure: while issue_ready=0, all output fields stay stable.
- Hazard history: a shift register of HAZARD_DIST-1 entries that shifts on every clk1 edge. It inserts {rd, writes} on a transfer and a null entry otherwise.
- Hazard: candidate rs1 or rs2 equals rd of a writing entry, checked against:
  - the output register, when issue_valid=1;
  - any history entry.
- Each RUN cycle blocked only by hazard increments bubble_cnt.
- Required result: with issue_ready=1, a dependent instruction transfers exactly HAZARD_DIST+1 cycles after its producer.
- Simultaneous start and prog_we in IDLE: the write happens and RUN is entered. The new word is fetched if written at address 0.

Optional Feature:
FD_HAZARD_INTERLOCK_EN
- Defined: interlock and bubble_cnt behave as above.
- Undefined: no hazard check; history logic is removed; bubble_cnt is tied to 0; instructions issue back-to-back.

Decomposition:
- Shared package pipe_pkg holds:
  - INSTR_W=24 and field bit offsets;
  - FUNC_ADD..FUNC_SHL (0-11) and FUNC_HALT=15;
  - the fd_state_t enum {IDLE, RUN, HALT};
  - a decoded-instruction struct.
- One sub-module: fd_hazard_unit (history shift register plus comparators). The FD_HAZARD_INTERLOCK_EN guard wraps its instantiation.

Test Plan:
- Program [ADD r10=r6+r4 addr125; MUL r10=r7*r8 addr126; HALT], ready=1, interlock on -> two transfers on consecutive cycles (no read of r10); halted=1; pc=2; bubble_cnt=0.
- Program [ADD r10=r6+r4; ADD r11=r10+r1; HALT] -> second transfer 3 cycles after first; bubble_cnt=2. Same program without the macro -> back-to-back transfers, bubble_cnt=0.
- Hold issue_ready=0 for 4 cycles after the first valid -> fields stable; pc unchanged; one transfer on release.
- IMEM_DEPTH=64, no HALT, 70 independent issues -> pc wraps 63->0; 65th transfer carries imem[0].
- Assert rst_n=0 mid-RUN with issue_valid=1 -> outputs 0 immediately (async); IDLE; program memory intact. Then start -> re-issues imem[0].
- prog_we in RUN to address 3 -> memory unchanged. Same write in HALT, then start -> new word at address 3 issued.
